// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared fetch-stage types, defaults and opcode constants
package fetch_unit_pkg;

  localparam int ADDR_W_DEF  = 10;
  localparam int INSTR_W_DEF = 16;
  localparam int RESET_PC_DEF = 0;

  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t ST_REQ    = 2'd0;
  localparam fetch_state_t ST_ISSUE  = 2'd1;
  localparam fetch_state_t ST_HALTED = 2'd2;
  localparam fetch_state_t ST_ERROR  = 2'd3;

  // Decoder opcodes; the fetch stage itself never decodes them.
  localparam logic [3:0] OP_HALT = 4'h0;
  localparam logic [3:0] OP_JMPL = 4'hD;
  localparam logic [3:0] OP_JMPE = 4'hE;
  localparam logic [3:0] OP_JMP  = 4'hF;

endpackage

// File: rtl/fetch_wait_timer.sv
// rtl/fetch_wait_timer.sv - counts consecutive unanswered fetch cycles
module fetch_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  // Fires on the cycle whose increment would bring the count to MAX_WAIT.
  assign expire = en && !clr && (count == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem handshake, issue hold, watchdog
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int INSTR_W  = INSTR_W_DEF,
  parameter int RESET_PC = RESET_PC_DEF,
  parameter int MAX_WAIT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  output logic [3:0]         opcode,
  output logic [11:0]        operand,
  output logic               instr_valid,
  input  logic               exec_done,
  input  logic               halt,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               resume,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted,
  output logic               fetch_err
);

  fetch_state_t state;
  logic         wait_clr;
  logic         wait_en;
  logic         wait_expire;

  assign wait_en  = (state == ST_REQ) && !imem_valid;
  assign wait_clr = (state != ST_REQ) || imem_valid;

  fetch_wait_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (wait_clr),
    .en    (wait_en),
    .expire(wait_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_REQ;
      pc      <= ADDR_W'(RESET_PC);
      opcode  <= '0;
      operand <= '0;
    end else begin
      case (state)
        ST_REQ: begin
          // A returning word beats the watchdog on the same cycle.
          if (imem_valid) begin
            opcode  <= imem_rdata[15:12];
            operand <= imem_rdata[11:0];
            state   <= ST_ISSUE;
          end else if (wait_expire) begin
            state <= ST_ERROR;
          end
        end
        ST_ISSUE: begin
          if (exec_done) begin
            if (halt) begin
              pc    <= pc + 1'b1;
              state <= ST_HALTED;
            end else if (branch_taken) begin
              pc    <= branch_target;
              state <= ST_REQ;
            end else begin
              pc    <= pc + 1'b1;
              state <= ST_REQ;
            end
          end
        end
        ST_HALTED: begin
          if (resume) begin
            state <= ST_REQ;
          end
        end
        default: state <= ST_ERROR;
      endcase
    end
  end

  // Reset parks the FSM in REQ, so the request is gated off until rst_n rises.
  assign imem_req    = rst_n && (state == ST_REQ);
  assign imem_addr   = pc;
  assign instr_valid = (state == ST_ISSUE);
  assign halted      = (state == ST_HALTED);
  assign fetch_err   = (state == ST_ERROR);

endmodule
